// File: rtl/npu_config_sequencer.sv
// npu_config_sequencer
// Pops 26-bit words from a first-word-fall-through config FIFO and turns each
// into one registered, addressed write to an NPU configuration target. Every
// target has its own auto-incrementing address counter. Select 8 is illegal
// and is dropped. Select 15 clears all counters and holds the NPU in reset
// for RST_CYCLES cycles.
module npu_config_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_enable,
    input  logic              npu_busy,
    input  logic              cfg_fifo_empty,
    input  logic [25:0]       cfg_fifo_dout,
    output logic              cfg_fifo_rd_en,
    output logic              wr_en,
    output logic [3:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              npu_rst,
    output logic              err_illegal,
    output logic              addr_wrap,
    output logic              seq_idle
);

    localparam int          HC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(RST_CYCLES - 1);
    localparam logic [3:0]  SEL_ILLEGAL = 4'd8;
    localparam logic [3:0]  SEL_NPURST  = 4'd15;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [HC_W-1:0]    r_hold_cnt;
    logic [ADDR_W-1:0]  r_cnt [0:15];
    logic               r_wr_en;
    logic [3:0]         r_wr_sel;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [15:0]        r_wr_data;
    logic               r_err_illegal;
    logic               r_addr_wrap;

    logic               w_pop;
    logic [3:0]         w_sel;
    logic               w_is_write;
    logic               w_unused_reserved;

    // Reserved bits [21:16] carry no meaning for the sequencer.
    assign w_unused_reserved = ^cfg_fifo_dout[21:16];

    assign w_sel      = cfg_fifo_dout[25:22];
    assign w_is_write = (w_sel != SEL_ILLEGAL) && (w_sel != SEL_NPURST);

    // Pop only in RUN; RST gating keeps a word from being lost during reset.
    assign w_pop = (r_state == ST_RUN) & cfg_enable & ~npu_busy & ~cfg_fifo_empty & ~RST;

    assign cfg_fifo_rd_en = w_pop;
    assign wr_en          = r_wr_en;
    assign wr_sel         = r_wr_sel;
    assign wr_addr        = r_wr_addr;
    assign wr_data        = r_wr_data;
    assign err_illegal    = r_err_illegal;
    assign addr_wrap      = r_addr_wrap;
    assign npu_rst        = RST | (r_state == ST_HOLD);
    assign seq_idle       = (r_state == ST_RUN) & cfg_fifo_empty & ~r_wr_en & ~RST;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a popped select-15 enters HOLD; HOLD lasts RST_CYCLES cycles.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_pop && (w_sel == SEL_NPURST)) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == HC_LAST) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Counts cycles spent in HOLD; sits at zero while running.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_HOLD) begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
        end else begin
            r_hold_cnt <= '0;
        end
    end

    // Write datapath, per-target address counters and sticky flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_en       <= 1'b0;
            r_wr_sel      <= 4'd0;
            r_wr_addr     <= '0;
            r_wr_data     <= 16'd0;
            r_err_illegal <= 1'b0;
            r_addr_wrap   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_wr_en <= 1'b0;
            if (w_pop) begin
                if (w_is_write) begin
                    r_wr_en       <= 1'b1;
                    r_wr_sel      <= w_sel;
                    r_wr_addr     <= r_cnt[w_sel];
                    r_wr_data     <= cfg_fifo_dout[15:0];
                    r_cnt[w_sel]  <= r_cnt[w_sel] + ADDR_W'(1);
                    if (&r_cnt[w_sel]) begin
                        r_addr_wrap <= 1'b1;
                    end
                end else if (w_sel == SEL_ILLEGAL) begin
                    r_err_illegal <= 1'b1;
                end else begin
                    // NPU reset word: every target starts again at address 0.
                    for (int i = 0; i < 16; i++) begin
                        r_cnt[i] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_npu_config_sequencer.sv
// Self-checking bench for npu_config_sequencer: a table of streamed words with
// hand-computed writes, plus hand-written sequences for NPU reset, busy stall,
// reset during HOLD and address wrap (on a second instance with ADDR_W=2).
module tb_npu_config_sequencer;

    logic        CLK;
    logic        RST;
    logic        cfg_enable;
    logic        npu_busy;
    logic        cfg_fifo_empty;
    logic [25:0] cfg_fifo_dout;

    logic        d1_rd_en, d1_wr_en, d1_npu_rst, d1_err, d1_wrap, d1_idle;
    logic [3:0]  d1_wr_sel;
    logic [7:0]  d1_wr_addr;
    logic [15:0] d1_wr_data;

    logic        d2_rd_en, d2_wr_en, d2_npu_rst, d2_err, d2_wrap, d2_idle;
    logic [3:0]  d2_wr_sel;
    logic [1:0]  d2_wr_addr;
    logic [15:0] d2_wr_data;

    int checks = 0;
    int errors = 0;

    // FIFO stimulus store (first-word-fall-through)
    logic [25:0] fifo_mem [0:63];
    int          fifo_wp = 0;
    int          fifo_rp = 0;

    assign cfg_fifo_empty = (fifo_rp == fifo_wp);
    assign cfg_fifo_dout  = fifo_mem[fifo_rp[5:0]];

    always @(posedge CLK) begin
        if (d1_rd_en) fifo_rp <= fifo_rp + 1;
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    npu_config_sequencer #(.ADDR_W(8), .RST_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .cfg_enable(cfg_enable), .npu_busy(npu_busy),
        .cfg_fifo_empty(cfg_fifo_empty), .cfg_fifo_dout(cfg_fifo_dout),
        .cfg_fifo_rd_en(d1_rd_en), .wr_en(d1_wr_en), .wr_sel(d1_wr_sel),
        .wr_addr(d1_wr_addr), .wr_data(d1_wr_data), .npu_rst(d1_npu_rst),
        .err_illegal(d1_err), .addr_wrap(d1_wrap), .seq_idle(d1_idle)
    );

    npu_config_sequencer #(.ADDR_W(2), .RST_CYCLES(4)) dut2 (
        .CLK(CLK), .RST(RST), .cfg_enable(cfg_enable), .npu_busy(npu_busy),
        .cfg_fifo_empty(cfg_fifo_empty), .cfg_fifo_dout(cfg_fifo_dout),
        .cfg_fifo_rd_en(d2_rd_en), .wr_en(d2_wr_en), .wr_sel(d2_wr_sel),
        .wr_addr(d2_wr_addr), .wr_data(d2_wr_data), .npu_rst(d2_npu_rst),
        .err_illegal(d2_err), .addr_wrap(d2_wrap), .seq_idle(d2_idle)
    );

    typedef struct {
        int          grp;
        logic [25:0] word;
        logic        exp_wr;
        logic [3:0]  exp_sel;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic logic [25:0] mkword(input logic [3:0] sel, input logic [15:0] data);
        // reserved field deliberately non-zero: it must be ignored
        return {sel, 6'h2A, data};
    endfunction

    function automatic vec_t mkvec(input int grp, input logic [3:0] sel, input logic [15:0] data,
                                   input logic wr, input logic [7:0] addr);
        vec_t v;
        v.grp      = grp;
        v.word     = mkword(sel, data);
        v.exp_wr   = wr;
        v.exp_sel  = sel;
        v.exp_addr = addr;
        v.exp_data = data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [25:0] w);
        fifo_mem[fifo_wp[5:0]] = w;
        fifo_wp = fifo_wp + 1;
    endtask

    task automatic chk_write(input string name, input logic [3:0] sel, input logic [7:0] addr,
                             input logic [15:0] data);
        chk({name, "_wr_en"},   {31'd0, d1_wr_en}, 32'd1);
        chk({name, "_wr_sel"},  {28'd0, d1_wr_sel}, {28'd0, sel});
        chk({name, "_wr_addr"}, {24'd0, d1_wr_addr}, {24'd0, addr});
        chk({name, "_wr_data"}, {16'd0, d1_wr_data}, {16'd0, data});
    endtask

    initial begin
        // group 0: three sel-2 words
        vecs[0]  = mkvec(0, 4'd2, 16'h1111, 1'b1, 8'd0);
        vecs[1]  = mkvec(0, 4'd2, 16'h2222, 1'b1, 8'd1);
        vecs[2]  = mkvec(0, 4'd2, 16'h3333, 1'b1, 8'd2);
        // group 1: interleaved sel 0 / sel 9, independent counters
        vecs[3]  = mkvec(1, 4'd0, 16'h0A00, 1'b1, 8'd0);
        vecs[4]  = mkvec(1, 4'd9, 16'h9900, 1'b1, 8'd0);
        vecs[5]  = mkvec(1, 4'd0, 16'h0A01, 1'b1, 8'd1);
        vecs[6]  = mkvec(1, 4'd9, 16'h9901, 1'b1, 8'd1);
        vecs[7]  = mkvec(1, 4'd0, 16'h0A02, 1'b1, 8'd2);
        vecs[8]  = mkvec(1, 4'd9, 16'h9902, 1'b1, 8'd2);
        vecs[9]  = mkvec(1, 4'd0, 16'h0A03, 1'b1, 8'd3);
        vecs[10] = mkvec(1, 4'd9, 16'h9903, 1'b1, 8'd3);
        // group 2: illegal select dropped, then sel 1
        vecs[11] = mkvec(2, 4'd8, 16'hDEAD, 1'b0, 8'd0);
        vecs[12] = mkvec(2, 4'd1, 16'hBEEF, 1'b1, 8'd0);

        RST        = 1'b1;
        cfg_enable = 1'b1;
        npu_busy   = 1'b0;

        // reset values
        repeat (2) @(negedge CLK);
        chk("rst_wr_en",   {31'd0, d1_wr_en}, 32'd0);
        chk("rst_wr_sel",  {28'd0, d1_wr_sel}, 32'd0);
        chk("rst_wr_addr", {24'd0, d1_wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, d1_wr_data}, 32'd0);
        chk("rst_err",     {31'd0, d1_err}, 32'd0);
        chk("rst_wrap",    {31'd0, d1_wrap}, 32'd0);
        chk("rst_npu_rst", {31'd0, d1_npu_rst}, 32'd1);
        chk("rst_rd_en",   {31'd0, d1_rd_en}, 32'd0);
        chk("rst_idle",    {31'd0, d1_idle}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_idle",    {31'd0, d1_idle}, 32'd1);
        chk("post_rst_npu_rst", {31'd0, d1_npu_rst}, 32'd0);

        // table-driven streaming groups
        for (int g = 0; g < 3; g++) begin
            cfg_enable = 1'b0;
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].grp == g) push(vecs[i].word);
            end
            cfg_enable = 1'b1;
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].grp == g) begin
                    @(negedge CLK);
                    if (vecs[i].exp_wr) begin
                        chk_write($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_addr,
                                  vecs[i].exp_data);
                    end else begin
                        chk($sformatf("vec%0d_no_wr", i), {31'd0, d1_wr_en}, 32'd0);
                    end
                end
            end
            @(negedge CLK);
            chk($sformatf("grp%0d_idle", g), {31'd0, d1_idle}, 32'd1);
            chk($sformatf("grp%0d_wr_off", g), {31'd0, d1_wr_en}, 32'd0);
        end
        chk("err_illegal_set", {31'd0, d1_err}, 32'd1);

        // sel 5, sel 15 (NPU reset), sel 5
        push(mkword(4'd5, 16'h5005));
        push(mkword(4'd15, 16'h0000));
        push(mkword(4'd5, 16'h5115));
        @(negedge CLK);
        chk_write("s5a", 4'd5, 8'd0, 16'h5005);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk($sformatf("hold%0d_npu_rst", c), {31'd0, d1_npu_rst}, 32'd1);
            chk($sformatf("hold%0d_rd_en", c),   {31'd0, d1_rd_en}, 32'd0);
            chk($sformatf("hold%0d_wr_en", c),   {31'd0, d1_wr_en}, 32'd0);
        end
        @(negedge CLK);
        chk("hold_exit_npu_rst", {31'd0, d1_npu_rst}, 32'd0);
        chk("hold_exit_rd_en",   {31'd0, d1_rd_en}, 32'd1);
        @(negedge CLK);
        chk_write("s5b", 4'd5, 8'd0, 16'h5115);
        chk("err_sticky_after_15", {31'd0, d1_err}, 32'd1);

        // busy stall
        npu_busy = 1'b1;
        push(mkword(4'd4, 16'h4440));
        push(mkword(4'd4, 16'h4441));
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            chk($sformatf("busy%0d_rd_en", c), {31'd0, d1_rd_en}, 32'd0);
            chk($sformatf("busy%0d_wr_en", c), {31'd0, d1_wr_en}, 32'd0);
        end
        npu_busy = 1'b0;
        @(negedge CLK);
        chk_write("busy_w0", 4'd4, 8'd0, 16'h4440);
        @(negedge CLK);
        chk_write("busy_w1", 4'd4, 8'd1, 16'h4441);

        // RST asserted in the middle of HOLD
        push(mkword(4'd15, 16'h0000));
        push(mkword(4'd6, 16'h6666));
        @(negedge CLK);
        chk("mh_npu_rst", {31'd0, d1_npu_rst}, 32'd1);
        @(negedge CLK);
        chk("mh_rd_en", {31'd0, d1_rd_en}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("mh_rst_wr_en",   {31'd0, d1_wr_en}, 32'd0);
        chk("mh_rst_wr_sel",  {28'd0, d1_wr_sel}, 32'd0);
        chk("mh_rst_wr_addr", {24'd0, d1_wr_addr}, 32'd0);
        chk("mh_rst_wr_data", {16'd0, d1_wr_data}, 32'd0);
        chk("mh_rst_err",     {31'd0, d1_err}, 32'd0);
        chk("mh_rst_rd_gated", {31'd0, d1_rd_en}, 32'd0);
        chk("mh_rst_npu_rst", {31'd0, d1_npu_rst}, 32'd1);
        RST = 1'b0;
        #1;
        chk("mh_run_npu_rst", {31'd0, d1_npu_rst}, 32'd0);
        chk("mh_run_rd_en",   {31'd0, d1_rd_en}, 32'd1);
        @(negedge CLK);
        chk_write("mh_w", 4'd6, 8'd0, 16'h6666);

        // address wrap on the ADDR_W=2 instance
        for (int i = 0; i < 5; i++) push(mkword(4'd3, 16'hA000 + 16'(i)));
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("wrap%0d_wr_en", i), {31'd0, d2_wr_en}, 32'd1);
            chk($sformatf("wrap%0d_addr", i), {30'd0, d2_wr_addr}, 32'(i % 4));
            chk($sformatf("wrap%0d_data", i), {16'd0, d2_wr_data}, 32'hA000 + 32'(i));
            chk($sformatf("wrap%0d_flag", i), {31'd0, d2_wrap}, (i >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("nowrap%0d_addr", i), {24'd0, d1_wr_addr}, 32'(i));
        end
        @(negedge CLK);
        chk("wrap_sticky", {31'd0, d2_wrap}, 32'd1);
        chk("wide_no_wrap", {31'd0, d1_wrap}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
